// File: rtl/usb_tx_crc16_append.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_tx_crc16_append: payload stream to TX byte stage with USB CRC16 tail.   |
// | Optional PID prefix byte when USB_TX_PID_EN is defined.                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module usb_tx_crc16_append #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
  parameter int          MAX_LEN  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_data,
  input  logic       zlp,
`ifdef USB_TX_PID_EN
  input  logic [3:0] pid,
`endif
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       trunc_err
);

  localparam int                 c_cnt_w = $clog2(MAX_LEN + 1);
  localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_LEN);

`ifdef USB_TX_PID_EN
  typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_CRC_LO, S_CRC_HI} state_t;
`endif

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_crc, w_crc_nxt;
  logic [c_cnt_w-1:0] r_count, w_count_nxt, w_count_inc;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic               r_tx_valid, w_tx_valid_nxt;
  logic               r_trunc_err, w_trunc_nxt;
  logic               w_free, w_in_ready;

  // Reflected (LSB-first) form of polynomial 0x8005, one byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign w_free      = !r_tx_valid || tx_ready;
  assign w_in_ready  = (r_state == S_DATA) && w_free;
  assign w_count_inc = r_count + c_cnt_w'(1);

`ifdef USB_TX_PID_EN
  logic [3:0] r_pid;
  logic       r_zlp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pid <= 4'h0;
      r_zlp <= 1'b0;
    end else if (r_state == S_IDLE && send_data) begin
      r_pid <= pid;
      r_zlp <= zlp;
    end
  end
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_crc_nxt      = r_crc;
    w_count_nxt    = r_count;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid && !tx_ready;
    w_trunc_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (send_data) begin
          w_crc_nxt   = CRC_INIT;
          w_count_nxt = '0;
`ifdef USB_TX_PID_EN
          w_state_nxt = S_PID;
`else
          w_state_nxt = zlp ? S_CRC_LO : S_DATA;
`endif
        end
      end
`ifdef USB_TX_PID_EN
      S_PID: begin
        if (w_free) begin
          w_tx_data_nxt  = {~r_pid, r_pid};
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = r_zlp ? S_CRC_LO : S_DATA;
        end
      end
`endif
      S_DATA: begin
        if (in_valid && w_in_ready) begin
          w_tx_data_nxt  = in_data;
          w_tx_valid_nxt = 1'b1;
          w_crc_nxt      = crc16_byte(r_crc, in_data);
          w_count_nxt    = w_count_inc;
          if (in_last) begin
            w_state_nxt = S_CRC_LO;
          end else if (w_count_inc == c_max) begin
            // Over-long packet: close it here as if this byte were the last.
            w_trunc_nxt = 1'b1;
            w_state_nxt = S_CRC_LO;
          end
        end
      end
      S_CRC_LO: begin
        if (w_free) begin
          w_tx_data_nxt  = ~r_crc[7:0];
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (w_free) begin
          w_tx_data_nxt  = ~r_crc[15:8];
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_crc       <= CRC_INIT;
      r_count     <= '0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_trunc_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_crc       <= w_crc_nxt;
      r_count     <= w_count_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_trunc_err <= w_trunc_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = (r_state != S_IDLE);
  assign trunc_err = r_trunc_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_crc16_append.sv
`default_nettype none
// Directed and randomised packets against a bit-serial CRC16 reference model.
module tb_usb_tx_crc16_append;

  logic       clk = 1'b0, reset = 1'b0, send_data = 1'b0, zlp = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, tx_ready = 1'b0, sel4 = 1'b0;
  logic [7:0] in_data = 8'h00;
`ifdef USB_TX_PID_EN
  logic [3:0] pid = 4'h0;
  localparam int PID_OFF = 1;
`else
  localparam int PID_OFF = 0;
`endif

  logic       send_a, send_b;
  logic       in_ready_a, tx_valid_a, busy_a, trunc_a;
  logic       in_ready_b, tx_valid_b, busy_b, trunc_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       in_ready_o, tx_valid_o, busy_o, trunc_o;
  logic [7:0] tx_data_o;

  assign send_a     = send_data && !sel4;
  assign send_b     = send_data && sel4;
  assign in_ready_o = sel4 ? in_ready_b : in_ready_a;
  assign tx_valid_o = sel4 ? tx_valid_b : tx_valid_a;
  assign tx_data_o  = sel4 ? tx_data_b  : tx_data_a;
  assign busy_o     = sel4 ? busy_b     : busy_a;
  assign trunc_o    = sel4 ? trunc_b    : trunc_a;

  usb_tx_crc16_append dut (
    .clk(clk), .reset(reset), .send_data(send_a), .zlp(zlp),
`ifdef USB_TX_PID_EN
    .pid(pid),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
    .busy(busy_a), .trunc_err(trunc_a)
  );

  usb_tx_crc16_append #(.MAX_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .send_data(send_b), .zlp(zlp),
`ifdef USB_TX_PID_EN
    .pid(pid),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
    .busy(busy_b), .trunc_err(trunc_b)
  );

  always #5 clk = ~clk;

  int         total = 0, bad = 0;
  int         trunc_hits = 0, accepted = 0, used_cycles = 0;
  logic [7:0] trunc_byte = 8'h00;
  logic [7:0] pay[$];
  logic [7:0] capq[$];
  logic [7:0] expq[$];
  bit         prev_stall = 0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Textbook MSB-first CRC over bits taken LSB-first, then bit-reversed and inverted.
  function automatic logic [15:0] usb_crc(input int n);
    logic [15:0] r, o;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[15] ^ pay[i][b];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    for (int k = 0; k < 16; k++) o[k] = r[15-k];
    return ~o;
  endfunction

  // Transfer capture, stall stability and truncation pulse tracking.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", {15'd0, tx_valid_o}, 16'd1);
        chk("stall_hold_data", {8'd0, tx_data_o}, {8'd0, prev_data});
      end
      if (tx_valid_o && tx_ready) capq.push_back(tx_data_o);
      if (trunc_o) begin
        trunc_hits++;
        trunc_byte = tx_data_o;
      end
      prev_stall = tx_valid_o && !tx_ready;
      prev_data  = tx_data_o;
    end
  end

  // mode 0: tx_ready always 1; 1: toggling; 2: random ready and input gaps.
  task automatic send_pkt(input string tag, input bit z, input int mode, input int n,
                          input bit use_last, input bit on4);
    int          idx, cyc, maxl, exp_acc;
    bit          done, exp_trunc, acc_pending;
    logic [7:0]  acc_byte;
    logic [15:0] c;
    maxl      = on4 ? 4 : 1024;
    exp_acc   = z ? 0 : ((n > maxl) ? maxl : n);
    exp_trunc = !z && (n > maxl || (!use_last && n == maxl));
    @(posedge clk); #1;
    sel4 = on4;
    capq.delete();
    trunc_hits = 0;
    expq.delete();
`ifdef USB_TX_PID_EN
    expq.push_back({~pid, pid});
`endif
    for (int i = 0; i < exp_acc; i++) expq.push_back(pay[i]);
    c = usb_crc(exp_acc);
    expq.push_back(c[7:0]);
    expq.push_back(c[15:8]);
    send_data = 1'b1; zlp = z; in_valid = 1'b0; in_last = 1'b0; tx_ready = 1'b1;
    @(posedge clk); #1;
    send_data = 1'b0;
    idx = 0; cyc = 1; done = 0; acc_pending = 0; acc_byte = 8'h00;
    while (!done && cyc < 400) begin
      if (acc_pending) begin
        chk({tag, "_latency_valid"}, {15'd0, tx_valid_o}, 16'd1);
        chk({tag, "_latency_data"}, {8'd0, tx_data_o}, {8'd0, acc_byte});
      end
      acc_pending = 0;
      if (!busy_o) begin
        done = 1;
        chk({tag, "_busy_drop_valid"}, {15'd0, tx_valid_o}, 16'd1);
        chk({tag, "_busy_drop_hi"}, {8'd0, tx_data_o}, {8'd0, expq[expq.size()-1]});
      end else begin
        case (mode)
          0:       tx_ready = 1'b1;
          1:       tx_ready = cyc[0];
          default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        in_valid = (idx < n) && (mode != 2 || $urandom_range(0, 3) != 0);
        in_data  = (idx < n) ? pay[idx] : 8'h00;
        in_last  = use_last && (idx == n - 1);
        #1;
        if (tx_valid_o && !tx_ready) chk({tag, "_stall_in_ready"}, {15'd0, in_ready_o}, 16'd0);
        if (in_valid && in_ready_o) begin
          acc_pending = 1;
          acc_byte    = in_data;
          idx++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!done) chk({tag, "_timeout_busy"}, {15'd0, busy_o}, 16'd0);
    in_valid = 1'b0; in_last = 1'b0; tx_ready = 1'b1;
    @(posedge clk); #1;
    accepted    = idx;
    used_cycles = cyc;
    chk({tag, "_accepted"}, 16'(idx), 16'(exp_acc));
    chk({tag, "_trunc_pulses"}, 16'(trunc_hits), exp_trunc ? 16'd1 : 16'd0);
    if (exp_trunc && exp_acc > 0) chk({tag, "_trunc_byte"}, {8'd0, trunc_byte}, {8'd0, pay[exp_acc-1]});
    if (mode == 0) chk({tag, "_cycles"}, 16'(cyc), 16'(exp_acc + 3 + PID_OFF));
    chk({tag, "_len"}, 16'(capq.size()), 16'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      chk({tag, "_byte"}, (i < capq.size()) ? {8'd0, capq[i]} : 16'hFFFF, {8'd0, expq[i]});
    chk({tag, "_idle_valid"}, {15'd0, tx_valid_o}, 16'd0);
  endtask

  task automatic load_123456789();
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
  endtask

  task automatic chk_check_value(input string tag);
    if (capq.size() >= 11 + PID_OFF) begin
      chk({tag, "_crc_lo"}, {8'd0, capq[9+PID_OFF]}, 16'h00C8);
      chk({tag, "_crc_hi"}, {8'd0, capq[10+PID_OFF]}, 16'h00B4);
    end else begin
      chk({tag, "_short_stream"}, 16'(capq.size()), 16'(11 + PID_OFF));
    end
  endtask

  initial begin
    #1;
    chk("rst_tx_valid", {15'd0, tx_valid_o}, 16'd0);
    chk("rst_tx_data", {8'd0, tx_data_o}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready_o}, 16'd0);
    chk("rst_busy", {15'd0, busy_o}, 16'd0);
    chk("rst_trunc", {15'd0, trunc_o}, 16'd0);
    #20 reset = 1'b1;

    pay.delete();
`ifdef USB_TX_PID_EN
    pid = 4'h5;
`endif
    send_pkt("zlp", 1'b1, 0, 0, 1'b1, 1'b0);
    if (capq.size() >= 2 + PID_OFF) begin
      chk("zlp_b0", {8'd0, capq[PID_OFF]}, 16'h0000);
      chk("zlp_b1", {8'd0, capq[PID_OFF+1]}, 16'h0000);
    end

    load_123456789();
`ifdef USB_TX_PID_EN
    pid = 4'h3;
`endif
    send_pkt("chk9", 1'b0, 0, 9, 1'b1, 1'b0);
    chk_check_value("chk9");
`ifdef USB_TX_PID_EN
    if (capq.size() > 0) chk("chk9_pid", {8'd0, capq[0]}, 16'h00C3);
`endif

    send_pkt("toggle", 1'b0, 1, 9, 1'b1, 1'b0);
    chk_check_value("toggle");

    pay.delete();
    for (int i = 0; i < 6; i++) pay.push_back(8'($urandom));
    send_pkt("trunc", 1'b0, 0, 6, 1'b0, 1'b1);

    // Abort a packet while CRC_LO waits behind a stalled payload byte.
    @(posedge clk); #1;
    sel4 = 1'b0; send_data = 1'b1; zlp = 1'b0; tx_ready = 1'b0;
    @(posedge clk); #1;
    send_data = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    chk("abort_pre_valid", {15'd0, tx_valid_o}, 16'd1);
    chk("abort_pre_busy", {15'd0, busy_o}, 16'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_valid", {15'd0, tx_valid_o}, 16'd0);
    chk("abort_busy", {15'd0, busy_o}, 16'd0);
    chk("abort_data", {8'd0, tx_data_o}, 16'd0);
    chk("abort_in_ready", {15'd0, in_ready_o}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b1; tx_ready = 1'b1;
    load_123456789();
    send_pkt("after_abort", 1'b0, 0, 9, 1'b1, 1'b0);
    chk_check_value("after_abort");

    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 20);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
`ifdef USB_TX_PID_EN
      pid = 4'($urandom);
`endif
      send_pkt("rand", 1'b0, 2, n, 1'b1, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      int n;
      bit ul;
      n  = $urandom_range(1, 8);
      ul = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      send_pkt("rand4", 1'b0, 2, n, ul, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
